// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response channels and a fixed access latency.
module data_mem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 17,
  parameter int LATENCY   = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_type,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_BITS - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]           cnt;
  logic                 we_q;
  logic [2:0]           type_q;
  logic [WIDTH-1:0]     addr_q;
  logic [WIDTH-1:0]     wdata_q;

  logic                 accept;
  logic                 commit;
  logic                 cur_we;
  logic [2:0]           cur_type;
  logic [WIDTH-1:0]     cur_addr;
  logic [WIDTH-1:0]     cur_wdata;

  logic                 illegal;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 err;

  logic [ADDR_BITS-3:0] idx;
  logic [1:0]           ofs;
  logic [7:0]           mem [4][DEPTH];
  logic [31:0]          word;
  logic [31:0]          shifted;
  logic [3:0]           lane_en;
  logic [31:0]          lane_data;
  logic [WIDTH-1:0]     load_data;

  assign accept = req_valid && req_ready;

  // With LATENCY 1 the commit edge is the accept edge, so use the live request
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_type  = (state == IDLE) ? req_type  : type_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (cur_we || err) ? '0 : load_data;
      end else if (state == RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= req_we;
      type_q  <= req_type;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: req_ready = !rst;
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign commit = (state != RESP) && (state_nx == RESP) && !rst;

  always_comb begin
    illegal = 1'b0;
    unique case (cur_type)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = cur_we;
      default:                illegal = 1'b1;
    endcase
  end

  assign misaligned =
    (cur_type[1:0] == 2'b01 && cur_addr[0]) ||
    (cur_type[1:0] == 2'b10 && cur_addr[1:0] != 2'b00);
  assign out_of_range = cur_addr[WIDTH-1:ADDR_BITS] != '0;
  assign err = illegal || misaligned || out_of_range;

  assign idx = cur_addr[ADDR_BITS-1:2];
  assign ofs = cur_addr[1:0];

  assign word = {mem[3][idx], mem[2][idx],
                 mem[1][idx], mem[0][idx]};
  assign shifted = word >> {ofs, 3'b000};

  always_comb begin
    load_data = '0;
    unique case (cur_type)
      3'b000: load_data =
        {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001: load_data =
        {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010: load_data = WIDTH'(word);
      3'b100: load_data =
        {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101: load_data =
        {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = cur_wdata[31:0];
    unique case (cur_type[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << ofs;
        lane_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = 4'b0011 << ofs;
        lane_data = {2{cur_wdata[15:0]}};
      end
      2'b10: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Memory contents survive reset; only a clean commit may write
  always_ff @(posedge CLK) begin
    if (commit && cur_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[i][idx] <= lane_data[8*i +: 8];
      end
    end
  end

endmodule
